// File: rtl/mips_mult_pkg.sv
// Shared definitions between the multiply controller and the shift-add multiplication unit.
package mips_mult_pkg;

  localparam int unsigned STATE_W = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PROD_W  = 2 * DATA_W;

  // State codes understood by the multiplication unit
  localparam logic [STATE_W-1:0] MULT_IDLE = 6'd0;
  localparam logic [STATE_W-1:0] MULT_INIT = 6'd1;
  localparam logic [STATE_W-1:0] MULT_WORK = 6'd2;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_INIT = 2'd1,
    C_WORK = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO storage; a product write overrides any move-to write in the same cycle.
module hilo_regs
  import mips_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              prod_we,
  input  logic [PROD_W-1:0] prod,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (prod_we) begin
      hi_d = prod[PROD_W-1:DATA_W];
      lo_d = prod[DATA_W-1:0];
    end else begin
      if (hi_we) hi_d = wr_data;
      if (lo_we) lo_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mult_control.sv
// Sequences the unsigned shift-add multiplier, applies sign magnitude for MULT,
// and owns HI/LO including the move-to ports.
module mult_control
  import mips_mult_pkg::*;
(
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic               mthi,
  input  logic               mtlo,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               mult_end,
  input  logic [PROD_W-1:0]  mult_result,
  output logic [STATE_W-1:0] mult_state,
  output logic [DATA_W-1:0]  mult_lhs,
  output logic [DATA_W-1:0]  mult_rhs,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo,
  output logic               busy,
  output logic               done
);

  ctrl_state_t       state_q, state_d;
  logic [DATA_W-1:0] lhs_q, lhs_d;
  logic [DATA_W-1:0] rhs_q, rhs_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hi_we_c, lo_we_c, prod_we_c;
  logic [PROD_W-1:0] prod_c;

  // Next-state, operand capture and HI/LO write enables
  always_comb begin
    state_d   = state_q;
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    hi_we_c   = 1'b0;
    lo_we_c   = 1'b0;
    prod_we_c = 1'b0;

    case (state_q)
      C_IDLE: begin
        hi_we_c = mthi;
        lo_we_c = mtlo;
        if (start) begin
          // 0x80000000 negates to itself, which the unsigned multiplier reads as 2^31
          lhs_d   = (signed_op && op_a[DATA_W-1]) ? (~op_a + DATA_W'(1)) : op_a;
          rhs_d   = (signed_op && op_b[DATA_W-1]) ? (~op_b + DATA_W'(1)) : op_b;
          neg_d   = signed_op & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
          state_d = C_INIT;
        end
      end
      C_INIT: state_d = C_WORK;
      C_WORK: begin
        if (mult_end) begin
          prod_we_c = 1'b1;
          done_d    = 1'b1;
          state_d   = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase

    busy_d = (state_d != C_IDLE);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= C_IDLE;
      lhs_q   <= '0;
      rhs_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    case (state_q)
      C_INIT:  mult_state = MULT_INIT;
      C_WORK:  mult_state = MULT_WORK;
      default: mult_state = MULT_IDLE;
    endcase
  end

  assign prod_c = neg_q ? (~mult_result + PROD_W'(1)) : mult_result;

  hilo_regs u_hilo_regs (
    .clk     (Clk),
    .rst     (reset),
    .hi_we   (hi_we_c),
    .lo_we   (lo_we_c),
    .wr_data (wr_data),
    .prod_we (prod_we_c),
    .prod    (prod_c),
    .hi      (hi),
    .lo      (lo)
  );

  assign mult_lhs = lhs_q;
  assign mult_rhs = rhs_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mult_control.sv
// Directed bench for mult_control with a cycle-accurate model of the shift-add multiplier.
module tb_mult_control;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] op_a, op_b;
  logic        mthi, mtlo;
  logic [31:0] wr_data;
  logic        mult_end;
  logic [63:0] mult_result;
  logic [5:0]  mult_state;
  logic [31:0] mult_lhs, mult_rhs, hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  mult_control dut (
    .Clk         (Clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wr_data     (wr_data),
    .mult_end    (mult_end),
    .mult_result (mult_result),
    .mult_state  (mult_state),
    .mult_lhs    (mult_lhs),
    .mult_rhs    (mult_rhs),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done)
  );

  // Multiplier model: loads on the INIT edge, 32 shift edges, endSignal on the following edge
  logic [5:0] shift_cnt;
  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      shift_cnt   <= '0;
      mult_end    <= 1'b0;
      mult_result <= '0;
    end else if (mult_state == 6'd1) begin
      shift_cnt   <= '0;
      mult_end    <= 1'b0;
      mult_result <= 64'(mult_lhs) * 64'(mult_rhs);
    end else if (mult_state == 6'd2) begin
      if (shift_cnt == 6'd32) mult_end  <= 1'b1;
      else                    shift_cnt <= shift_cnt + 6'd1;
    end else begin
      mult_end <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Full transaction; inject=1 fires a start (9x9) plus mtlo at E10 that must be ignored
  task automatic run_mult(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lhs, input logic [31:0] exp_rhs,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic inject);
    start = 1'b1; signed_op = sg; op_a = a; op_b = b;
    tick();                                   // E0
    start = 1'b0;
    check({tag, ".busy_e0"}, 64'(busy), 64'd1);
    check({tag, ".state_init"}, 64'(mult_state), 64'd1);
    check({tag, ".lhs"}, 64'(mult_lhs), 64'(exp_lhs));
    check({tag, ".rhs"}, 64'(mult_rhs), 64'(exp_rhs));
    tick();                                   // E1
    check({tag, ".state_work"}, 64'(mult_state), 64'd2);
    for (int e = 2; e <= 34; e++) begin
      if (inject && e == 10) begin
        start = 1'b1; signed_op = 1'b0; op_a = 32'd9; op_b = 32'd9;
        mtlo = 1'b1; wr_data = 32'h1234_5678;
      end
      tick();
      start = 1'b0; mtlo = 1'b0;
      if (inject && e == 10) begin
        check({tag, ".ign_lhs"}, 64'(mult_lhs), 64'(exp_lhs));
        check({tag, ".ign_state"}, 64'(mult_state), 64'd2);
      end
    end
    check({tag, ".busy_e34"}, 64'(busy), 64'd1);
    check({tag, ".done_e34"}, 64'(done), 64'd0);
    tick();                                   // E35
    check({tag, ".done_e35"}, 64'(done), 64'd1);
    check({tag, ".busy_e35"}, 64'(busy), 64'd0);
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    tick();                                   // E36
    check({tag, ".done_e36"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
    tick(); tick();
    check("rst.state", 64'(mult_state), 64'd0);
    check("rst.hilo", {hi, lo}, 64'd0);
    check("rst.lhs", 64'(mult_lhs), 64'd0);
    check("rst.busy_done", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    tick();

    run_mult("mulu_7x3", 1'b0, 32'd7, 32'd3, 32'd7, 32'd3, 32'h0, 32'h15, 1'b0);
    run_mult("mul_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_mult("mulu_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_mult("mul_ffxff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h0, 32'h1, 1'b0);
    run_mult("mul_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 32'h0, 1'b0);
    run_mult("mul_min_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1,
             32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_mult("mul_0_m7", 1'b1, 32'd0, 32'hFFFF_FFF9, 32'd0, 32'd7, 32'h0, 32'h0, 1'b0);

    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hA5A5_5A5A;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both.hi", 64'(hi), 64'hA5A5_5A5A);
    check("mt_both.lo", 64'(lo), 64'hA5A5_5A5A);

    mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    mthi = 1'b0;
    check("mthi.hi", 64'(hi), 64'hDEAD_BEEF);
    check("mthi.lo_kept", 64'(lo), 64'hA5A5_5A5A);

    run_mult("mulu_2x2_coll", 1'b0, 32'd2, 32'd2, 32'd2, 32'd2, 32'h0, 32'h4, 1'b1);

    // Start coinciding with mtlo: the move lands now, product overwrites it later
    mtlo = 1'b1; wr_data = 32'h0BAD_F00D;
    start = 1'b1; signed_op = 1'b0; op_a = 32'd5; op_b = 32'd5;
    tick();                                   // E0
    start = 1'b0; mtlo = 1'b0;
    check("coinc.lo_mt", 64'(lo), 64'h0BAD_F00D);
    for (int e = 1; e <= 9; e++) tick();
    reset = 1'b1;
    #1;
    check("midrst.hilo", {hi, lo}, 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.state", 64'(mult_state), 64'd0);
    tick();
    reset = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done) check("midrst.no_done", 64'(done), 64'd0);
    end
    check("midrst.idle_after", {62'd0, busy, done}, 64'd0);

    run_mult("mulu_5x5", 1'b0, 32'd5, 32'd5, 32'd5, 32'd5, 32'h0, 32'h19, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
